// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage ARM pipeline: forwarding, stalls, flushes,
// and long-multiply sequencing (enabled by defining HAZARD_LONGMUL_EN).
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Match_1E_M,
    input  logic       Match_1E_W,
    input  logic       Match_2E_M,
    input  logic       Match_2E_W,
    input  logic       Match_12D_E,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       LongE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MulBusy,
    output logic       MulDoneE,
    output logic       HiWriteW
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

    logic ldrstall, pcpend;
    logic fsm_stall, stall_e, mul_busy, mul_done, hi_wr;

    assign ldrstall = Match_12D_E & MemtoRegE;
    assign pcpend   = PCSrcD | PCSrcE | PCSrcM;

    // The HI slot is a register-file write just like RegWriteW, so it forwards from W too.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (Match_1E_M & RegWriteM)                ForwardAE = 2'b10;
        else if (Match_1E_W & (RegWriteW | hi_wr)) ForwardAE = 2'b01;
        if (Match_2E_M & RegWriteM)                ForwardBE = 2'b10;
        else if (Match_2E_W & (RegWriteW | hi_wr)) ForwardBE = 2'b01;
    end

`ifdef HAZARD_LONGMUL_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] hi_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi_pipe <= 3'b000;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi_pipe <= {hi_pipe[1:0], mul_done};
        end
    end

    // LongE is not looked at while BUSY: E is frozen, so it is still the same op.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        fsm_stall = 1'b0;
        stall_e   = 1'b0;
        mul_busy  = 1'b0;
        mul_done  = 1'b0;
        case (state)
            IDLE: begin
                if (LongE) begin
                    fsm_stall = 1'b1;
                    stall_e   = 1'b1;
                    mul_busy  = 1'b1;
                    state_n   = BUSY;
                    cnt_n     = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    fsm_stall = 1'b1;
                    stall_e   = 1'b1;
                    mul_busy  = 1'b1;
                    cnt_n     = cnt - 4'd1;
                end else begin
                    fsm_stall = 1'b1;
                    mul_done  = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign hi_wr = hi_pipe[2];
`else
    assign fsm_stall = 1'b0;
    assign stall_e   = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign hi_wr     = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, LongE, CNT_INIT};
`endif

    assign StallF   = ldrstall | pcpend | fsm_stall;
    assign StallD   = ldrstall | fsm_stall;
    assign StallE   = stall_e;
    assign FlushD   = pcpend | PCSrcW | BranchTakenE;
    assign FlushE   = (ldrstall | BranchTakenE | mul_done) & ~stall_e;
    assign MulBusy  = mul_busy;
    assign MulDoneE = mul_done;
    assign HiWriteW = hi_wr;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_LONGMUL_EN.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE, HiWriteW;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef HAZARD_LONGMUL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_12D_E(Match_12D_E),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .LongE(LongE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .MulBusy(MulBusy), .MulDoneE(MulDoneE), .HiWriteW(HiWriteW)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE, HiWriteW}
    logic [7:0] outs;
    assign outs = {StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE, HiWriteW};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = '0;
        {RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #3;
        n_checks++;
        if (outs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outs got=%b exp=%b", outs, 8'h00);
        end
        n_checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_fwd got=%b exp=0000", {ForwardAE, ForwardBE});
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        logic [5:0] vin [6];
        logic [3:0] vexp [6];
        // {M1M, M1W, M2M, M2W, RWM, RWW} -> {FA, FB}
        vin[0] = 6'b111111; vexp[0] = 4'b1010;
        vin[1] = 6'b111101; vexp[1] = 4'b0101;
        vin[2] = 6'b111100; vexp[2] = 4'b0000;
        vin[3] = 6'b100111; vexp[3] = 4'b1001;
        vin[4] = 6'b011010; vexp[4] = 4'b0010;
        vin[5] = 6'b000011; vexp[5] = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, RegWriteM, RegWriteW} = vin[i];
            #1;
            n_checks++;
            if ({ForwardAE, ForwardBE} !== vexp[i]) begin
                n_fail++;
                $display("FAIL forward[%0d] got=%b exp=%b", i, {ForwardAE, ForwardBE}, vexp[i]);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        Match_12D_E = 1'b1;
        MemtoRegE   = 1'b1;
        #3;
        n_checks++;
        if (outs !== 8'b1100_1000) begin
            n_fail++;
            $display("FAIL load_use got=%b exp=%b", outs, 8'b1100_1000);
        end
        tick();
        clear_inputs();
        #3;
        n_checks++;
        if (outs !== 8'h00) begin
            n_fail++;
            $display("FAIL load_use_release got=%b exp=%b", outs, 8'h00);
        end
        tick();
    endtask

    task automatic test_branch();
        BranchTakenE = 1'b1;
        #3;
        n_checks++;
        if (outs !== 8'b0001_1000) begin
            n_fail++;
            $display("FAIL branch_taken got=%b exp=%b", outs, 8'b0001_1000);
        end
        clear_inputs();
        PCSrcD = 1'b1;
        #1;
        n_checks++;
        if (outs !== 8'b1001_0000) begin
            n_fail++;
            $display("FAIL pcsrc_d got=%b exp=%b", outs, 8'b1001_0000);
        end
        clear_inputs();
        PCSrcW = 1'b1;
        #1;
        n_checks++;
        if (outs !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL pcsrc_w got=%b exp=%b", outs, 8'b0001_0000);
        end
        clear_inputs();
        tick();
    endtask

    // LongE pulsed for one cycle at k=0; with MUL_CYCLES=4 the done cycle is k=3, HI slot k=6.
    task automatic test_long_op();
        logic [7:0] exp_o;
        for (int k = 0; k < 9; k++) begin
            LongE = (k == 0);
            #3;
            case (k)
                0, 1, 2: exp_o = 8'hE4;
                3:       exp_o = 8'hCA;
                6:       exp_o = 8'h01;
                default: exp_o = 8'h00;
            endcase
            if (!EN) exp_o = 8'h00;
            n_checks++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL long_op k=%0d got=%b exp=%b", k, outs, exp_o);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] exp_o;
        for (int k = 0; k < 2; k++) begin
            LongE = (k == 0);
            tick();
        end
        LongE = 1'b0;
        #3;
        exp_o = EN ? 8'hE4 : 8'h00;
        n_checks++;
        if (outs !== exp_o) begin
            n_fail++;
            $display("FAIL pre_reset_busy got=%b exp=%b", outs, exp_o);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_op got=%b exp=%b", outs, 8'h00);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #3;
            n_checks++;
            if (outs !== 8'h00) begin
                n_fail++;
                $display("FAIL after_reset k=%0d got=%b exp=%b", k, outs, 8'h00);
            end
            tick();
        end
    endtask

    // Two ops, LongE held while in E; second enters 3 cycles after the first's done cycle.
    task automatic test_back_to_back();
        logic [7:0] exp_o;
        logic [3:0] exp_f;
        Match_1E_W = 1'b1;
        Match_2E_W = 1'b1;
        for (int k = 0; k < 14; k++) begin
            LongE = (k <= 3) || (k >= 6 && k <= 9);
            #3;
            case (k)
                0, 1, 2, 7, 8: exp_o = 8'hE4;
                6:             exp_o = 8'hE5;
                3, 9:          exp_o = 8'hCA;
                12:            exp_o = 8'h01;
                default:       exp_o = 8'h00;
            endcase
            exp_f = (k == 6 || k == 12) ? 4'b0101 : 4'b0000;
            if (!EN) begin
                exp_o = 8'h00;
                exp_f = 4'b0000;
            end
            n_checks++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL b2b k=%0d got=%b exp=%b", k, outs, exp_o);
            end
            n_checks++;
            if ({ForwardAE, ForwardBE} !== exp_f) begin
                n_fail++;
                $display("FAIL b2b_fwd k=%0d got=%b exp=%b", k, {ForwardAE, ForwardBE}, exp_f);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        tick();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        do_reset();
        test_long_op();
        do_reset();
        test_reset_mid_op();
        do_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage pipelined ARM core. It generates the forwarding selects for the execute-stage source muxes, the stall/flush controls for the F/D and D/E pipeline registers, and load-use and branch bubbles. It also sequences multi-cycle long multiplies: it holds the op in Execute for `MUL_CYCLES` cycles, then schedules a dedicated writeback slot for the high result word, because the register file has a single write port.

## Interface
- `MUL_CYCLES`, default 4: cycles a long multiply occupies Execute; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `Match_1E_M`, `Match_1E_W`, `Match_2E_M`, `Match_2E_W`  in  1 each  E-stage source register equals M/W destination.
- `Match_12D_E`  in  1  a D-stage source equals the E-stage destination.
- `RegWriteM`, `RegWriteW`  in  1 each  register write enables in M and W.
- `MemtoRegE`  in  1  E-stage instruction is a load.
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW`  in  1 each  PC-writing instruction in that stage.
- `BranchTakenE`  in  1  branch resolved taken in E.
- `LongE`  in  1  valid long multiply in E; the datapath clears it on bubbles.
- `ForwardAE`, `ForwardBE`  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM.
- `StallF`, `StallD`, `StallE`  out  1 each  1 = hold the stage register.
- `FlushD`, `FlushE`  out  1 each  1 = load a bubble.
- `MulBusy`  out  1  long op held in E.
- `MulDoneE`  out  1  last E cycle of a long op.
- `HiWriteW`  out  1  W slot writes RdHi; the datapath muxes WA3/WD3 accordingly.

## Operation
- **Forwarding (A; B symmetric):**
  - `ForwardAE = 10` if `Match_1E_M & RegWriteM`.
  - Otherwise `01` if `Match_1E_W & (RegWriteW | HiWriteW)`.
  - Otherwise `00`. M has priority over W.
- **Load-use:** `ldrstall = Match_12D_E & MemtoRegE`.
- **PC pending:** `pcpend = PCSrcD | PCSrcE | PCSrcM`.
- **Long-op FSM states:** IDLE, BUSY; 4-bit down-counter `cnt`.
  - IDLE with `LongE`: assert `StallF`, `StallD`, `StallE`, `MulBusy`; next state BUSY, `cnt = MUL_CYCLES-2`.
  - BUSY with `cnt != 0`: same stalls and `MulBusy`; `cnt` decrements.
  - BUSY with `cnt == 0`: assert `MulDoneE`, `StallF`, `StallD`, `FlushE`; `StallE = 0`. The op advances to M with a bubble behind it. Next state IDLE.
- **HI-slot shift register** `hi_pipe[2:0]`:
  - Shifts every cycle; `hi_pipe[0] <= MulDoneE`.
  - `HiWriteW = hi_pipe[2]`, which coincides with the bubble reaching W one cycle after the op's Lo write.
  - Overlapping sequences are legal; the register tracks each independently.
- **Combined outputs:**
  - `StallF = ldrstall | pcpend | fsm_stall`.
  - `StallD = ldrstall | fsm_stall`.
  - `FlushD = pcpend | PCSrcW | BranchTakenE`.
  - `FlushE = (ldrstall | BranchTakenE | MulDoneE) & ~StallE`.
  - `StallE` has priority over every flush of E.
- **Reset:** state IDLE, `cnt = 0`, `hi_pipe = 0`. With all inputs low, every output is 0.

## Timing
- Forward, stall and flush outputs are combinational from inputs and current state, with no added latency. `HiWriteW` is registered.
- A long op entering E at cycle t:
  - Stays in E through t+MUL_CYCLES-1 (`MulDoneE` high there).
  - Is in W at t+MUL_CYCLES+1.
  - `HiWriteW` is high at t+MUL_CYCLES+2.
- Back-to-back long ops: the second reaches E at the earliest 3 cycles after the first's `MulDoneE`. FSM re-entry from IDLE is legal while `hi_pipe` is non-zero.
- Reset asserted mid-sequence clears the FSM and `hi_pipe` immediately; no `HiWriteW` is emitted afterwards.
- `LongE` while BUSY is ignored; E is frozen, so it is the same op.
- `BranchTakenE` during BUSY cannot occur. If asserted, `StallE` still wins and `FlushD` follows the formula.

## Configuration
- `HAZARD_LONGMUL_EN`
  - Defined: FSM, counter and `hi_pipe` are present as above.
  - Undefined: `LongE` is ignored; `MulBusy`, `MulDoneE`, `HiWriteW` and `StallE` are tied 0; forwarding uses `RegWriteW` only. The `MUL_CYCLES` parameter is accepted but unused.

## Test plan
- **Forward priority:** `Match_1E_M = Match_1E_W = RegWriteM = RegWriteW = 1` -> `ForwardAE = 10`. Drop `RegWriteM` -> `01`. Both enables 0 -> `00`.
- **Load-use:** `Match_12D_E = MemtoRegE = 1` -> `StallF = StallD = FlushE = 1` for exactly that cycle, `FlushD = 0`.
- **Branch:** `BranchTakenE = 1` -> `FlushD = FlushE = 1`, `StallF = 0`. `PCSrcD = 1` -> `StallF = FlushD = 1`.
- **Long op, `MUL_CYCLES = 4`:** pulse `LongE` at cycle 10 ->
  - `StallE` high at cycles 10–12.
  - `MulDoneE` and `FlushE` high at 13.
  - `HiWriteW` high at 16 only.
- **Reset mid-op:** assert `reset` at cycle 12 of the previous scenario -> `MulBusy`, `HiWriteW` and all stalls 0 immediately. No `HiWriteW` after release.
- **Macro off:** same `LongE` stimulus -> `StallE`, `MulBusy`, `MulDoneE`, `HiWriteW` all 0 throughout.
